// File: rtl/sdf_twiddle_seq.sv
// Twiddle sequencer for one radix-2 SDF FFT stage: fill/butterfly/twiddle phase and W=exp(-j*pi*k/DELAY).
// Define TWIDDLE_QUARTER_ROM_EN to store only the cosine quarter table (needs DELAY >= 2).
module sdf_twiddle_seq #(
    parameter int DATA_W    = 24,
    parameter int FRAC_W    = 8,
    parameter int DELAY     = 2,
    parameter int FRAME_LEN = 512,
    localparam int KW = (DELAY > 1) ? $clog2(DELAY) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     sync,
    output logic                     out_valid,
    output logic [1:0]               state,
    output logic signed [DATA_W-1:0] w_r,
    output logic signed [DATA_W-1:0] w_i,
    output logic [KW-1:0]            tw_idx,
    output logic                     frame_done
);

    localparam int  FW = $clog2(DELAY + 1);
    localparam int  PW = $clog2(2 * DELAY);
    localparam int  NW = $clog2(FRAME_LEN);
    localparam real PI = 3.14159265358979323846;
    localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_W);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_BFLY = 2'd1,
        S_TWID = 2'd2
    } phase_e;

    function automatic real f_cos(input real x);
        real t;
        real s;
        t = 1.0;
        s = 1.0;
        for (int n = 1; n < 30; n++) begin
            t = -t * x * x / (real'(2 * n - 1) * real'(2 * n));
            s = s + t;
        end
        return s;
    endfunction

    function automatic real f_sin(input real x);
        real t;
        real s;
        t = x;
        s = x;
        for (int n = 1; n < 30; n++) begin
            t = -t * x * x / (real'(2 * n) * real'(2 * n + 1));
            s = s + t;
        end
        return s;
    endfunction

    // Round to nearest, ties away from zero
    function automatic logic signed [DATA_W-1:0] f_q(input real v);
        real s;
        int  r;
        s = v * real'(1 << FRAC_W);
        if (s >= 0.0) r = $rtoi(s + 0.5);
        else          r = -$rtoi(0.5 - s);
        return DATA_W'(r);
    endfunction

    function automatic logic signed [DATA_W-1:0] f_cq(input int m);
        return f_q(f_cos(PI * real'(m) / real'(DELAY)));
    endfunction

    function automatic logic signed [DATA_W-1:0] f_sq(input int m);
        return f_q(f_sin(PI * real'(m) / real'(DELAY)));
    endfunction

    logic [FW-1:0]            r_fill, n_fill;
    logic [PW-1:0]            r_phase, n_phase;
    logic [NW-1:0]            r_frame, n_frame;
    logic                     r_valid, n_valid;
    logic                     r_done, n_done;
    phase_e                   r_state, n_state;
    logic signed [DATA_W-1:0] r_wr, n_wr;
    logic signed [DATA_W-1:0] r_wi, n_wi;
    logic [KW-1:0]            r_k, n_k;

    logic [PW-1:0]            w_kp;
    logic [KW-1:0]            w_k;
    logic signed [DATA_W-1:0] w_tr;
    logic signed [DATA_W-1:0] w_ti;

    assign w_kp = r_phase - PW'(DELAY);
    assign w_k  = w_kp[KW-1:0];

`ifdef TWIDDLE_QUARTER_ROM_EN
    localparam int H  = DELAY / 2;
    localparam int CW = $clog2(H + 1);

    logic signed [DATA_W-1:0] w_c [H+1];

    for (genvar g = 0; g <= H; g++) begin : g_cq
        assign w_c[g] = f_cq(g);
    end

    // Fold k onto the first quadrant using cosine symmetry
    always_comb begin
        if (int'(w_k) < H) begin
            w_tr = w_c[CW'(int'(w_k))];
            w_ti = -w_c[CW'(H - int'(w_k))];
        end else begin
            w_tr = -w_c[CW'(DELAY - int'(w_k))];
            w_ti = -w_c[CW'(int'(w_k) - H)];
        end
    end
`else
    logic signed [DATA_W-1:0] w_tab_r [DELAY];
    logic signed [DATA_W-1:0] w_tab_i [DELAY];

    for (genvar g = 0; g < DELAY; g++) begin : g_tab
        assign w_tab_r[g] = f_cq(g);
        assign w_tab_i[g] = -f_sq(g);
    end

    assign w_tr = w_tab_r[w_k];
    assign w_ti = w_tab_i[w_k];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill  <= '0;
            r_phase <= '0;
            r_frame <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_state <= S_FILL;
            r_wr    <= ONE;
            r_wi    <= '0;
            r_k     <= '0;
        end else begin
            r_fill  <= n_fill;
            r_phase <= n_phase;
            r_frame <= n_frame;
            r_valid <= n_valid;
            r_done  <= n_done;
            r_state <= n_state;
            r_wr    <= n_wr;
            r_wi    <= n_wi;
            r_k     <= n_k;
        end
    end

    always_comb begin
        n_fill  = r_fill;
        n_phase = r_phase;
        n_frame = r_frame;
        n_valid = 1'b0;
        n_done  = 1'b0;
        n_state = r_state;
        n_wr    = r_wr;
        n_wi    = r_wi;
        n_k     = r_k;
        if (sync) begin
            n_fill  = '0;
            n_phase = '0;
            n_frame = '0;
        end else if (in_valid) begin
            n_valid = 1'b1;
            if (r_fill < FW'(DELAY)) begin
                n_fill  = r_fill + 1'b1;
                n_state = S_FILL;
                n_wr    = ONE;
                n_wi    = '0;
                n_k     = '0;
            end else begin
                if (r_phase < PW'(DELAY)) begin
                    n_state = S_BFLY;
                    n_wr    = ONE;
                    n_wi    = '0;
                    n_k     = '0;
                end else begin
                    n_state = S_TWID;
                    n_wr    = w_tr;
                    n_wi    = w_ti;
                    n_k     = w_k;
                end
                n_phase = (r_phase == PW'(2 * DELAY - 1)) ? '0 : r_phase + 1'b1;
                n_done  = (r_frame == NW'(FRAME_LEN - 1));
                n_frame = n_done ? '0 : r_frame + 1'b1;
            end
        end
    end

    assign out_valid  = r_valid;
    assign frame_done = r_done;
    assign state      = r_state;
    assign w_r        = r_wr;
    assign w_i        = r_wi;
    assign tw_idx     = r_k;

endmodule
